// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 main control FSM: fetch/decode/execute/memory/writeback sequencing with memory-handshake timeout.
// Optional instruction-retire counter enabled by defining MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] op,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg2loc,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        err,
    output logic [3:0]  state
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_R   = 4'd6,
        S_WB_LD  = 4'd7,
        S_BRANCH = 4'd8,
        S_ERROR  = 4'd15
    } state_t;

    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           cur, nxt;
    logic [CNT_W-1:0] cnt;
    logic             waiting;
    logic             tmo_hit;
    logic             is_r, is_ldur, is_stur, is_cbz;

    assign is_r    = (op == 11'b10001011000) || (op == 11'b11001011000) ||
                     (op == 11'b10001010000) || (op == 11'b10101010000);
    assign is_ldur = (op == 11'b11111000010);
    assign is_stur = (op == 11'b11111000000);
    assign is_cbz  = (op[10:3] == 8'b10110100);

    assign tmo_hit = (TIMEOUT != 0) && (cnt == TMO);
    assign state   = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_FETCH;
            cnt <= '0;
        end else begin
            cur <= nxt;
            // Any state change re-arms the counter for the next handshake.
            if (nxt != cur)
                cnt <= '0;
            else if (waiting && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        nxt        = cur;
        waiting    = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        err        = 1'b0;
        case (cur)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end else if (tmo_hit) begin
                    nxt = S_ERROR;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                reg2loc = is_stur || is_cbz;
                if (is_r)                   nxt = S_EXEC_R;
                else if (is_ldur || is_stur) nxt = S_ADDR;
                else if (is_cbz)            nxt = S_BRANCH;
                else                        nxt = S_ERROR;
            end
            S_EXEC_R: begin
                alu_op = 2'b10;
                nxt    = S_WB_R;
            end
            S_WB_R: begin
                alu_op    = 2'b10;
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_ADDR: begin
                alu_src = 1'b1;
                nxt     = is_stur ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                alu_src  = 1'b1;
                if (dmem_ready)   nxt = S_WB_LD;
                else if (tmo_hit) nxt = S_ERROR;
                else              waiting = 1'b1;
            end
            S_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                reg2loc   = 1'b1;
                alu_src   = 1'b1;
                if (dmem_ready)   nxt = S_FETCH;
                else if (tmo_hit) nxt = S_ERROR;
                else              waiting = 1'b1;
            end
            S_BRANCH: begin
                alu_op   = 2'b01;
                reg2loc  = 1'b1;
                pc_src   = 1'b1;
                pc_write = zero;
                nxt      = S_FETCH;
            end
            S_ERROR: begin
                err = 1'b1;
            end
            default: begin
                nxt = S_ERROR;
            end
        endcase
        // Reset silences every strobe, including the one for the aborted instruction.
        if (reset) begin
            imem_req   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg2loc    = 1'b0;
            alu_src    = 1'b0;
            alu_op     = 2'b00;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            err        = 1'b0;
        end
    end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic retire;

    assign retire = (cur == S_WB_R) || (cur == S_WB_LD) || (cur == S_BRANCH) ||
                    ((cur == S_MEM_WR) && dmem_ready);

    always_ff @(posedge clk) begin
        if (reset)
            retired <= '0;
        else if (retire)
            retired <= retired + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors with hand-computed state/strobe expectations.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] op;
    logic        zero, imem_ready, dmem_ready;
    logic        imem_req, ir_write, pc_write, pc_src, reg2loc, alu_src;
    logic [1:0]  alu_op;
    logic        mem_read, mem_write, mem_to_reg, reg_write, err;
    logic [3:0]  state;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .err(err), .state(state)
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    // Output vector: imem_req ir_write pc_write pc_src reg2loc alu_src alu_op[1:0]
    //                mem_read mem_write mem_to_reg reg_write err
    localparam logic [12:0] O_NONE  = 13'b0_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] O_FWAIT = 13'b1_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] O_FGO   = 13'b1_1_1_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] O_DEC1  = 13'b0_0_0_0_1_0_00_0_0_0_0_0;
    localparam logic [12:0] O_EXR   = 13'b0_0_0_0_0_0_10_0_0_0_0_0;
    localparam logic [12:0] O_WBR   = 13'b0_0_0_0_0_0_10_0_0_0_1_0;
    localparam logic [12:0] O_ADDR  = 13'b0_0_0_0_0_1_00_0_0_0_0_0;
    localparam logic [12:0] O_MRD   = 13'b0_0_0_0_0_1_00_1_0_0_0_0;
    localparam logic [12:0] O_WBLD  = 13'b0_0_0_0_0_0_00_0_0_1_1_0;
    localparam logic [12:0] O_MWR   = 13'b0_0_0_0_1_1_00_0_1_0_0_0;
    localparam logic [12:0] O_BR1   = 13'b0_0_1_1_1_0_01_0_0_0_0_0;
    localparam logic [12:0] O_BR0   = 13'b0_0_0_1_1_0_01_0_0_0_0_0;
    localparam logic [12:0] O_ERR   = 13'b0_0_0_0_0_0_00_0_0_0_0_1;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    typedef struct {
        logic [3:0]  st;
        logic [12:0] o;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    logic [12:0] act_o;
    assign act_o = {imem_req, ir_write, pc_write, pc_src, reg2loc, alu_src, alu_op,
                    mem_read, mem_write, mem_to_reg, reg_write, err};

    // Drive one cycle's inputs just after the edge and record what the DUT must show in it.
    task automatic cyc(input logic rs, input logic [10:0] o, input logic z,
                       input logic ir, input logic dr,
                       input logic [3:0] es, input logic [12:0] eo, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rs; op = o; zero = z; imem_ready = ir; dmem_ready = dr;
        e.st = es; e.o = eo; e.tag = tag;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
            end
            checks++;
            if (act_o !== e.o) begin
                errors++;
                $display("FAIL %s outputs: got %b expected %b", e.tag, act_o, e.o);
            end
        end
    end

    initial begin
        reset = 1'b1; op = OP_ADD; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        @(posedge clk);
        cyc(1, OP_ADD, 0, 1, 1, 4'd0, O_NONE, "reset");

        // ADD with both readies high
        cyc(0, OP_ADD, 0, 1, 1, 4'd0, O_FGO,  "add_fetch");
        cyc(0, OP_ADD, 0, 1, 1, 4'd1, O_NONE, "add_dec");
        cyc(0, OP_ADD, 0, 1, 1, 4'd2, O_EXR,  "add_exec");
        cyc(0, OP_ADD, 0, 1, 1, 4'd6, O_WBR,  "add_wb");

        // LDUR, dmem_ready low for 3 cycles
        cyc(0, OP_LDUR, 0, 1, 0, 4'd0, O_FGO,  "ld_fetch");
        cyc(0, OP_LDUR, 0, 1, 0, 4'd1, O_NONE, "ld_dec");
        cyc(0, OP_LDUR, 0, 1, 0, 4'd3, O_ADDR, "ld_addr");
        cyc(0, OP_LDUR, 0, 1, 0, 4'd4, O_MRD,  "ld_mem0");
        cyc(0, OP_LDUR, 0, 1, 0, 4'd4, O_MRD,  "ld_mem1");
        cyc(0, OP_LDUR, 0, 1, 0, 4'd4, O_MRD,  "ld_mem2");
        cyc(0, OP_LDUR, 0, 1, 1, 4'd4, O_MRD,  "ld_mem3");
        cyc(0, OP_LDUR, 0, 1, 1, 4'd7, O_WBLD, "ld_wb");

        // STUR fast path
        cyc(0, OP_STUR, 0, 1, 1, 4'd0, O_FGO,  "st_fetch");
        cyc(0, OP_STUR, 0, 1, 1, 4'd1, O_DEC1, "st_dec");
        cyc(0, OP_STUR, 0, 1, 1, 4'd3, O_ADDR, "st_addr");
        cyc(0, OP_STUR, 0, 1, 1, 4'd5, O_MWR,  "st_mem");

        // CBZ taken then not taken
        cyc(0, OP_CBZ, 1, 1, 1, 4'd0, O_FGO,  "cbz1_fetch");
        cyc(0, OP_CBZ, 1, 1, 1, 4'd1, O_DEC1, "cbz1_dec");
        cyc(0, OP_CBZ, 1, 1, 1, 4'd8, O_BR1,  "cbz1_br");
        cyc(0, OP_CBZ, 0, 1, 1, 4'd0, O_FGO,  "cbz0_fetch");
        cyc(0, OP_CBZ, 0, 1, 1, 4'd1, O_DEC1, "cbz0_dec");
        cyc(0, OP_CBZ, 0, 1, 1, 4'd8, O_BR0,  "cbz0_br");

        // ORR, then fetch waits with ready rising exactly at count 4
        cyc(0, OP_ORR, 0, 1, 1, 4'd0, O_FGO,  "orr_fetch");
        cyc(0, OP_ORR, 0, 1, 1, 4'd1, O_NONE, "orr_dec");
        cyc(0, OP_ORR, 0, 1, 1, 4'd2, O_EXR,  "orr_exec");
        cyc(0, OP_ORR, 0, 1, 1, 4'd6, O_WBR,  "orr_wb");
        for (int i = 0; i < 4; i++)
            cyc(0, OP_ADD, 0, 0, 1, 4'd0, O_FWAIT, "late_wait");
        cyc(0, OP_ADD, 0, 1, 1, 4'd0, O_FGO,  "late_go");
        cyc(0, OP_ADD, 0, 1, 1, 4'd1, O_NONE, "late_dec");
        cyc(0, OP_ADD, 0, 1, 1, 4'd2, O_EXR,  "late_exec");
        cyc(0, OP_ADD, 0, 1, 1, 4'd6, O_WBR,  "late_wb");

        // Fetch timeout: five waiting cycles, then ERROR
        for (int i = 0; i < 5; i++)
            cyc(0, OP_ADD, 0, 0, 1, 4'd0, O_FWAIT, "tmo_wait");
        for (int i = 0; i < 3; i++)
            cyc(0, OP_ADD, 0, 1, 1, 4'd15, O_ERR, "tmo_err");
        cyc(1, OP_ADD, 0, 1, 1, 4'd15, O_NONE, "tmo_rst");

        // Illegal opcode traps and stays trapped
        cyc(0, OP_ILL, 0, 1, 1, 4'd0, O_FGO,  "ill_fetch");
        cyc(0, OP_ILL, 0, 1, 1, 4'd1, O_NONE, "ill_dec");
        for (int i = 0; i < 20; i++)
            cyc(0, OP_ILL, i[0], 1, 1, 4'd15, O_ERR, "ill_err");
        cyc(1, OP_ILL, 0, 1, 1, 4'd15, O_NONE, "ill_rst");
        cyc(0, OP_STUR, 0, 0, 0, 4'd0, O_FWAIT, "ill_after");

        // Reset during MEM_WR aborts the store
        cyc(0, OP_STUR, 0, 1, 0, 4'd0, O_FGO,  "ab_fetch");
        cyc(0, OP_STUR, 0, 1, 0, 4'd1, O_DEC1, "ab_dec");
        cyc(0, OP_STUR, 0, 1, 0, 4'd3, O_ADDR, "ab_addr");
        cyc(0, OP_STUR, 0, 1, 0, 4'd5, O_MWR,  "ab_mem");
        cyc(1, OP_STUR, 0, 1, 0, 4'd5, O_NONE, "ab_rst");
        cyc(0, OP_STUR, 0, 0, 0, 4'd0, O_FWAIT, "ab_after");

        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
